// File: rtl/keccak_byte_packer.sv
// Byte-stream to 32-bit word packer feeding the keccak core: big-endian packing, final-word
// marking with valid byte count, zero pad word for 4k-length messages, empty-message support.
module keccak_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  input  logic        msg_empty,
  output logic        byte_ready,
  output logic [31:0] in,
  output logic        in_ready,
  output logic        is_last,
  output logic [1:0]  byte_num,
  input  logic        buffer_full,
  output logic        msg_sent
);

  typedef enum logic [1:0] {StFill, StFinalPad, StFinal} state_e;

  state_e      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] in_q, in_d;
  logic        in_ready_q, in_ready_d;
  logic        is_last_q, is_last_d;
  logic [1:0]  byte_num_q, byte_num_d;
  logic        msg_sent_q, msg_sent_d;

  logic        take;
  logic        byte_acc;
  logic        empty_acc;
  logic [31:0] merged;

  assign in       = in_q;
  assign in_ready = in_ready_q;
  assign is_last  = is_last_q;
  assign byte_num = byte_num_q;
  assign msg_sent = msg_sent_q;

  always_comb begin
    take       = in_ready_q & ~buffer_full;
    byte_ready = reset & (state_q == StFill) & (~in_ready_q | ~buffer_full);
    byte_acc   = byte_valid & byte_ready;
    empty_acc  = msg_empty & ~byte_valid & (count_q == 2'd0) & byte_ready;
    // Accumulated lanes plus the incoming byte; lanes below it are forced to zero.
    unique case (count_q)
      2'd0:    merged = {byte_in, 24'h000000};
      2'd1:    merged = {acc_q[23:16], byte_in, 16'h0000};
      2'd2:    merged = {acc_q[23:8], byte_in, 8'h00};
      default: merged = {acc_q, byte_in};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    in_d       = in_q;
    in_ready_d = in_ready_q;
    is_last_d  = is_last_q;
    byte_num_d = byte_num_q;
    msg_sent_d = 1'b0;

    if (take) begin
      in_ready_d = 1'b0;
      is_last_d  = 1'b0;
      byte_num_d = 2'd0;
    end

    unique case (state_q)
      StFill: begin
        if (byte_acc) begin
          if ((count_q == 2'd3) || byte_last) begin
            in_d       = merged;
            in_ready_d = 1'b1;
            acc_d      = 24'h000000;
            count_d    = 2'd0;
            if (byte_last && (count_q != 2'd3)) begin
              is_last_d  = 1'b1;
              byte_num_d = count_q + 2'd1;
              state_d    = StFinal;
            end else begin
              is_last_d  = 1'b0;
              byte_num_d = 2'd0;
              if (byte_last) begin
                state_d = StFinalPad;
              end
            end
          end else begin
            acc_d   = merged[31:8];
            count_d = count_q + 2'd1;
          end
        end else if (empty_acc) begin
          in_d       = 32'h00000000;
          in_ready_d = 1'b1;
          is_last_d  = 1'b1;
          byte_num_d = 2'd0;
          state_d    = StFinal;
        end
      end
      StFinalPad: begin
        // Full final word is leaving; follow it immediately with the zero terminator.
        if (take) begin
          in_d       = 32'h00000000;
          in_ready_d = 1'b1;
          is_last_d  = 1'b1;
          byte_num_d = 2'd0;
          state_d    = StFinal;
        end
      end
      StFinal: begin
        if (take) begin
          msg_sent_d = 1'b1;
          state_d    = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFill;
      acc_q      <= 24'h000000;
      count_q    <= 2'd0;
      in_q       <= 32'h00000000;
      in_ready_q <= 1'b0;
      is_last_q  <= 1'b0;
      byte_num_q <= 2'd0;
      msg_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      in_q       <= in_d;
      in_ready_q <= in_ready_d;
      is_last_q  <= is_last_d;
      byte_num_q <= byte_num_d;
      msg_sent_q <= msg_sent_d;
    end
  end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Self-checking bench for keccak_byte_packer: table of messages with hand-computed words,
// plus directed sequences for msg_empty, backpressure and mid-message reset.
module tb_keccak_byte_packer;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];
  typedef struct packed {
    logic [31:0] w;
    logic        l;
    logic [1:0]  n;
  } word_t;
  typedef word_t wq_t[$];
  typedef struct {
    string       s;
    int          stall;
    logic [31:0] first_w;
    logic [31:0] pen_w;
    logic [31:0] last_w;
    logic [1:0]  last_n;
    int          nwords;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        msg_empty = 1'b0;
  logic        byte_ready;
  logic [31:0] in_w;
  logic        in_ready;
  logic        is_last;
  logic [1:0]  byte_num;
  logic        buffer_full = 1'b0;
  logic        msg_sent;

  int total = 0;
  int passed = 0;

  keccak_byte_packer dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .msg_empty  (msg_empty),
    .byte_ready (byte_ready),
    .in         (in_w),
    .in_ready   (in_ready),
    .is_last    (is_last),
    .byte_num   (byte_num),
    .buffer_full(buffer_full),
    .msg_sent   (msg_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs at the negedge; outputs read after this reflect all prior posedges.
  task automatic cyc_drive(input logic v, input logic [7:0] b, input logic l, input logic bf,
                           input logic me);
    @(negedge clk);
    byte_valid  = v;
    byte_in     = b;
    byte_last   = l;
    buffer_full = bf;
    msg_empty   = me;
    #1;
  endtask

  function automatic logic stall_of(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 3) == 1;
      2:       return (cyc >= 4) && (cyc <= 6);
      3:       return (cyc % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic wq_t model(input bq_t q);
    wq_t   r;
    word_t x;
    int    n;
    n = q.size();
    for (int k = 0; k < n / 4; k++) begin
      x.w = {q[4*k], q[4*k+1], q[4*k+2], q[4*k+3]};
      x.l = 1'b0;
      x.n = 2'd0;
      r.push_back(x);
    end
    x = '0;
    if (n % 4 == 0) begin
      x.l = 1'b1;
    end else begin
      for (int j = 0; j < n % 4; j++) x.w[31-8*j -: 8] = q[4*(n/4)+j];
      x.l = 1'b1;
      x.n = 2'(n % 4);
    end
    r.push_back(x);
    return r;
  endfunction

  task automatic run_bytes(input bq_t q, input int mode, output wq_t got);
    int    idx = 0;
    int    cyc = 0;
    int    sent = 0;
    logic  prev_hold = 1'b0;
    word_t prev = '0;
    word_t cur;
    wq_t   exp;
    got = {};
    while (cyc < 2000) begin
      @(negedge clk);
      buffer_full = stall_of(mode, cyc);
      msg_empty   = 1'b0;
      if (idx < q.size()) begin
        byte_valid = 1'b1;
        byte_in    = q[idx];
        byte_last  = (idx == q.size() - 1);
      end else begin
        byte_valid = 1'b0;
        byte_last  = 1'b0;
      end
      #1;
      cur = {in_w, is_last, byte_num};
      if (msg_sent) sent++;
      if (prev_hold) begin
        chk("held_word_stable", {in_ready, cur}, {1'b1, prev});
      end
      if (in_ready && buffer_full) chk("byte_ready_in_stall", byte_ready, 1'b0);
      if (in_ready && !buffer_full) got.push_back(cur);
      prev_hold = in_ready && buffer_full;
      prev      = cur;
      if (byte_valid && byte_ready) idx++;
      if (sent > 0) break;
      cyc++;
    end
    chk("msg_timeout", cyc < 2000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      byte_valid  = 1'b0;
      byte_last   = 1'b0;
      buffer_full = 1'b0;
      #1;
      if (msg_sent) sent++;
    end
    chk("msg_sent_pulses", sent, 1);
    exp = model(q);
    chk("word_count_model", got.size(), exp.size());
    for (int k = 0; k < got.size() && k < exp.size(); k++) chk("word_model", got[k], exp[k]);
  endtask

  initial begin
    vec_t  vecs[7];
    bq_t   q;
    wq_t   got;
    string fox;

    fox = "The quick brown fox jumps over the lazy dog";
    vecs[0] = '{fox, 0, 32'h54686520, 32'h617A7920, 32'h646F6700, 2'd3, 11};
    vecs[1] = '{{fox, "."}, 1, 32'h54686520, 32'h646F672E, 32'h00000000, 2'd0, 12};
    vecs[2] = '{"abcd", 3, 32'h61626364, 32'h61626364, 32'h00000000, 2'd0, 2};
    vecs[3] = '{"abcdefg", 0, 32'h61626364, 32'h61626364, 32'h65666700, 2'd3, 2};
    vecs[4] = '{"a", 1, 32'h61000000, 32'h0, 32'h61000000, 2'd1, 1};
    vecs[5] = '{"ab", 0, 32'h61620000, 32'h0, 32'h61620000, 2'd2, 1};
    vecs[6] = '{"wxyzWX", 2, 32'h7778797A, 32'h7778797A, 32'h57580000, 2'd2, 2};

    // Reset state
    cyc_drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("reset_byte_ready", byte_ready, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_outputs", {in_w, in_ready, is_last, byte_num, msg_sent}, 37'h0);
    reset = 1'b1;
    #1;
    chk("byte_ready_after_reset", byte_ready, 1'b1);

    for (int v = 0; v < 7; v++) begin
      q = {};
      for (int i = 0; i < vecs[v].s.len(); i++) q.push_back(vecs[v].s[i]);
      run_bytes(q, vecs[v].stall, got);
      chk($sformatf("v%0d_nwords", v), got.size(), vecs[v].nwords);
      if (got.size() > 0) begin
        chk($sformatf("v%0d_first", v), got[0].w, vecs[v].first_w);
        chk($sformatf("v%0d_last", v), got[got.size()-1],
            {vecs[v].last_w, 1'b1, vecs[v].last_n});
      end
      if (vecs[v].nwords >= 2 && got.size() >= 2) begin
        chk($sformatf("v%0d_penult", v), got[got.size()-2], {vecs[v].pen_w, 3'b000});
      end
    end

    // Five bytes A1..A5
    q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_bytes(q, 0, got);
    chk("a1_nwords", got.size(), 2);
    if (got.size() == 2) begin
      chk("a1_word0", got[0], {32'hA1A2A3A4, 3'b000});
      chk("a1_word1", got[1], {32'hA5000000, 1'b1, 2'd1});
    end

    // Empty message
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("empty_word", {in_w, in_ready, is_last, byte_num}, {32'h0, 1'b1, 1'b1, 2'd0});
    chk("empty_no_bytes", byte_ready, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("empty_sent", {msg_sent, in_ready}, 2'b10);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("empty_sent_once", msg_sent, 1'b0);

    // msg_empty with byte_valid: the byte wins
    cyc_drive(1'b1, 8'h41, 1'b1, 1'b0, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("empty_blocked", {in_w, in_ready, is_last, byte_num}, {32'h41000000, 1'b1, 1'b1, 2'd1});
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("empty_blocked_sent", msg_sent, 1'b1);

    // msg_empty ignored with a partial word
    cyc_drive(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("empty_ignored", in_ready, 1'b0);
    cyc_drive(1'b1, 8'h52, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("partial_after_ignore", {in_w, in_ready, is_last, byte_num},
        {32'h51520000, 1'b1, 1'b1, 2'd2});
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("partial_after_ignore_sent", msg_sent, 1'b1);

    // Reset while a word is held
    cyc_drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("held_before_reset", {in_w, in_ready}, {32'h10203040, 1'b1});
    reset = 1'b0;
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("held_reset_clears", {in_ready, is_last, byte_num, msg_sent}, 5'b0);
    reset = 1'b1;

    // Reset with two bytes accumulated, then a fresh 2-byte message
    cyc_drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc_drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    q = '{8'h01, 8'h02};
    run_bytes(q, 0, got);
    chk("reset_count_nwords", got.size(), 1);
    if (got.size() == 1) chk("reset_count_word", got[0], {32'h01020000, 1'b1, 2'd2});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
